// File: rtl/frogger_pkg.sv
// Shared types and constants for the frogger lane logic.
package frogger_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } lane_state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage : frogger_pkg

// File: rtl/lane_prescaler.sv
// Tick prescaler: counts enabled ticks and flags an advance once count reaches speed.
module lane_prescaler #(
  parameter int unsigned DIV_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick,
  input  logic             clr,
  input  logic [DIV_W-1:0] speed,
  input  logic             enable,
  output logic             adv
);

  logic [DIV_W-1:0] count_q;
  logic [DIV_W-1:0] count_d;

  // A lowered speed still fires on the next tick because the test is >=, not ==.
  assign adv = enable & tick & (count_q >= speed);

  // Next count: clear wins, an advance restarts, otherwise count enabled ticks.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (enable && tick) begin
      if (adv) count_d = '0;
      else     count_d = count_q + DIV_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule : lane_prescaler

// File: rtl/lane_scroller.sv
// One traffic lane: rotating car pattern, speed prescaler, sticky frog collision.
module lane_scroller
  import frogger_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIV_W = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     tick,
  input  logic                     load,
  input  logic [WIDTH-1:0]         load_pattern,
  input  logic                     dir,
  input  logic [DIV_W-1:0]         speed,
  input  logic [$clog2(WIDTH)-1:0] frog_col,
  input  logic                     frog_in_lane,
  input  logic                     clear_hit,
  output logic [WIDTH-1:0]         lane,
  output logic                     step,
  output logic                     hit,
  output logic                     running
);

  lane_state_e      state_q, state_d;
  logic [WIDTH-1:0] lane_q, lane_d;
  logic             step_q, step_d;
  logic             hit_q, hit_d;
  logic             running_q, running_d;
  logic             collide_c;
  logic             adv_c;

  // Collision is judged on the registered lane, so it lands one edge after a move.
  assign collide_c = frog_in_lane & lane_q[frog_col];

  lane_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .tick   (tick),
    .clr    (load),
    .speed  (speed),
    .enable ((state_q == RUN) & ~collide_c),
    .adv    (adv_c)
  );

  // Next state, lane rotation, step pulse and sticky hit.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    step_d  = 1'b0;
    hit_d   = hit_q;

    // A new collision beats a coincident clear.
    if (collide_c)      hit_d = 1'b1;
    else if (clear_hit) hit_d = 1'b0;

    if (load) begin
      state_d = RUN;
      lane_d  = load_pattern;
    end else begin
      unique case (state_q)
        RUN: begin
          if (collide_c) begin
            state_d = HALT;
          end else if (adv_c) begin
            step_d = 1'b1;
            if (dir == DIR_LEFT) lane_d = {lane_q[WIDTH-2:0], lane_q[WIDTH-1]};
            else                 lane_d = {lane_q[0], lane_q[WIDTH-1:1]};
          end
        end
        HALT: begin
          if (clear_hit && !collide_c) state_d = RUN;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    running_d = (state_d == RUN);
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      lane_q    <= '0;
      step_q    <= 1'b0;
      hit_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      step_q    <= step_d;
      hit_q     <= hit_d;
      running_q <= running_d;
    end
  end

  assign lane    = lane_q;
  assign step    = step_q;
  assign hit     = hit_q;
  assign running = running_q;

endmodule : lane_scroller

// File: tb/tb_lane_scroller.sv
// Directed bench for lane_scroller with hand-computed expectations.
module tb_lane_scroller;

  logic        clock;
  logic        reset;
  logic        tick;
  logic        load;
  logic [15:0] load_pattern;
  logic        dir;
  logic [3:0]  speed;
  logic [3:0]  frog_col;
  logic        frog_in_lane;
  logic        clear_hit;
  logic [15:0] lane;
  logic        step;
  logic        hit;
  logic        running;

  int n_chk;
  int n_pass;
  int n_step;

  lane_scroller #(
    .WIDTH (16),
    .DIV_W (4)
  ) u_dut (
    .clock        (clock),
    .reset        (reset),
    .tick         (tick),
    .load         (load),
    .load_pattern (load_pattern),
    .dir          (dir),
    .speed        (speed),
    .frog_col     (frog_col),
    .frog_in_lane (frog_in_lane),
    .clear_hit    (clear_hit),
    .lane         (lane),
    .step         (step),
    .hit          (hit),
    .running      (running)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compare one observed value with its expectation.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Advance one clock and settle just after the edge.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Load a pattern for one cycle.
  task automatic do_load(input logic [15:0] pat);
    load = 1'b1;
    load_pattern = pat;
    cyc();
    load = 1'b0;
  endtask

  logic [15:0] exp_lane;

  initial begin
    n_chk = 0; n_pass = 0;
    reset = 1'b0; tick = 1'b0; load = 1'b0; load_pattern = '0;
    dir = 1'b0; speed = '0; frog_col = '0; frog_in_lane = 1'b0; clear_hit = 1'b0;
    #12;
    check("rst_lane", 32'(lane), 32'h0);
    check("rst_step", 32'(step), 32'h0);
    check("rst_hit", 32'(hit), 32'h0);
    check("rst_running", 32'(running), 32'h0);
    #2 reset = 1'b1;

    // Idle: ticks are ignored.
    tick = 1'b1;
    repeat (3) cyc();
    tick = 1'b0;
    check("idle_lane", 32'(lane), 32'h0);
    check("idle_step", 32'(step), 32'h0);
    check("idle_running", 32'(running), 32'h0);

    // Left rotation at speed 0 through a full wrap.
    dir = 1'b0; speed = 4'd0;
    do_load(16'h0001);
    check("load_lane", 32'(lane), 32'h0001);
    check("load_running", 32'(running), 32'h1);
    n_step = 0;
    tick = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      cyc();
      exp_lane = (i == 16) ? 16'h0001 : (16'h0001 << i);
      check($sformatf("left_%0d", i), 32'(lane), 32'(exp_lane));
      if (step) n_step++;
    end
    tick = 1'b0;
    cyc();
    check("left_steps", 32'(n_step), 32'd16);
    check("left_step_drop", 32'(step), 32'h0);

    // Right rotation wraps bit 0 to the MSB.
    dir = 1'b1;
    do_load(16'h0001);
    tick = 1'b1; cyc(); tick = 1'b0;
    check("right_lane", 32'(lane), 32'h8000);
    check("right_step", 32'(step), 32'h1);

    // Speed 2: one rotation per three ticks.
    dir = 1'b0; speed = 4'd2;
    do_load(16'h0001);
    n_step = 0;
    tick = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cyc();
      if (step) n_step++;
    end
    tick = 1'b0;
    check("spd2_steps", 32'(n_step), 32'd3);
    check("spd2_lane", 32'(lane), 32'h0008);

    // Load on the second tick wins and restarts the count.
    cyc();
    tick = 1'b1; cyc();
    load = 1'b1; load_pattern = 16'h00F0; cyc(); load = 1'b0;
    check("ld_tick_lane", 32'(lane), 32'h00F0);
    check("ld_tick_step", 32'(step), 32'h0);
    cyc(); cyc();
    check("restart_hold", 32'(lane), 32'h00F0);
    cyc();
    tick = 1'b0;
    check("restart_rot", 32'(lane), 32'h01E0);

    // Lowering speed mid-count fires on the next tick.
    speed = 4'd7;
    do_load(16'h0001);
    tick = 1'b1;
    repeat (3) cyc();
    tick = 1'b0;
    check("slow_hold", 32'(lane), 32'h0001);
    speed = 4'd1;
    tick = 1'b1; cyc(); tick = 1'b0;
    check("speed_drop", 32'(lane), 32'h0002);

    // Collision: move a car under the frog, then halt.
    speed = 4'd0; frog_col = 4'd5; frog_in_lane = 1'b1;
    do_load(16'h0010);
    check("coll_pre_hit", 32'(hit), 32'h0);
    tick = 1'b1; cyc(); tick = 1'b0;
    check("coll_lane", 32'(lane), 32'h0020);
    check("coll_hit_lag", 32'(hit), 32'h0);
    cyc();
    check("coll_hit", 32'(hit), 32'h1);
    check("coll_halt", 32'(running), 32'h0);
    tick = 1'b1;
    repeat (4) cyc();
    tick = 1'b0;
    check("halt_lane", 32'(lane), 32'h0020);
    check("halt_step", 32'(step), 32'h0);
    clear_hit = 1'b1; cyc();
    check("clr_vs_set_hit", 32'(hit), 32'h1);
    check("clr_vs_set_run", 32'(running), 32'h0);
    frog_in_lane = 1'b0; cyc(); clear_hit = 1'b0;
    check("clr_hit", 32'(hit), 32'h0);
    check("clr_run", 32'(running), 32'h1);
    cyc();
    check("hit_sticky_off", 32'(hit), 32'h0);

    // Async reset mid-cycle while running.
    frog_col = 4'd0;
    do_load(16'h0F0F);
    check("pre_rst_lane", 32'(lane), 32'h0F0F);
    #2 reset = 1'b0;
    #1;
    check("arst_lane", 32'(lane), 32'h0);
    check("arst_running", 32'(running), 32'h0);
    check("arst_hit", 32'(hit), 32'h0);
    #2 reset = 1'b1;
    do_load(16'h00FF);
    check("post_rst_load", 32'(lane), 32'h00FF);
    check("post_rst_run", 32'(running), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_lane_scroller

// File: doc/lane_scroller.md
LANE_SCROLLER -- requirements
Module: lane_scroller

Interface
REQ-001 Parameter WIDTH, default 16: number of columns in one traffic lane; minimum 2.
REQ-002 Parameter DIV_W, default 4: width of the speed field.
REQ-003 clock  input  1  single system clock; all state updates on posedge clock.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 tick  input  1  one-cycle movement strobe from the game tick generator.
REQ-006 load  input  1  load load_pattern into the lane.
REQ-007 load_pattern  input  WIDTH  car pattern; bit i = car in column i.
REQ-008 dir  input  1  0 = rotate toward MSB (left), 1 = rotate toward LSB (right).
REQ-009 speed  input  DIV_W  lane advances once every speed+1 ticks.
REQ-010 frog_col  input  $clog2(WIDTH)  frog column.
REQ-011 frog_in_lane  input  1  frog occupies this lane.
REQ-012 clear_hit  input  1  clear sticky collision and resume.
REQ-013 lane  output  WIDTH  registered current car pattern.
REQ-014 step  output  1  one-cycle pulse, high in the cycle after lane has rotated.
REQ-015 hit  output  1  sticky collision flag.
REQ-016 running  output  1  high while the state is RUN.

Function
REQ-017 The state machine SHALL have states IDLE, RUN and HALT.
REQ-018 In IDLE, tick SHALL be ignored and lane SHALL hold its value.
REQ-019 load SHALL, in any state, move the state to RUN, set lane to load_pattern and clear the tick count on the next edge.
REQ-020 load SHALL take priority over a coincident tick: no rotation occurs and the tick is not counted.
REQ-021 In RUN, when tick=1 and tick count >= speed, lane SHALL rotate by one column in direction dir, the tick count SHALL return to 0, and step SHALL be 1 for exactly the following cycle.
REQ-022 In RUN, when tick=1 and tick count < speed, the tick count SHALL increment and lane SHALL hold.
REQ-023 Rotation SHALL wrap: left maps bit WIDTH-1 to bit 0; right maps bit 0 to bit WIDTH-1.
REQ-024 Lowering speed mid-count SHALL cause a shift on the next tick, per the >= rule.
REQ-025 Collision SHALL be evaluated on the registered lane: when frog_in_lane=1 and lane[frog_col]=1, hit SHALL be set on the next edge.
REQ-026 A hit SHALL move RUN to HALT on the same edge.
REQ-027 In HALT, ticks SHALL be ignored and lane SHALL freeze.
REQ-028 hit SHALL remain set until clear_hit is sampled high.
REQ-029 clear_hit SHALL clear hit and move HALT to RUN on the next edge.
REQ-030 If clear_hit and a new collision occur in the same cycle, the set SHALL win.
REQ-031 step SHALL never be high in IDLE or HALT, except for the one-cycle trailing pulse of a rotation that has already occurred.

Reset
REQ-032 When reset=0, the block SHALL immediately, without a clock edge, force lane=0, tick count=0, step=0, hit=0, running=0 and state=IDLE.
REQ-033 Reset SHALL release synchronously to clock; the first edge after release SHALL be able to accept load.

Structure
REQ-034 Package frogger_pkg SHALL hold the lane_state_e enum (IDLE, RUN, HALT) and the constants DIR_LEFT=0 and DIR_RIGHT=1.
REQ-035 The tick count and compare logic SHALL be a sub-module, lane_prescaler (inputs clock, reset, tick, clr, speed, enable; output adv).
REQ-036 All outputs SHALL be driven directly from flops.

Verification
REQ-037 Reset asserted while in RUN with lane=16'h0F0F -> lane=0, state IDLE and running=0 before the next clock edge.
REQ-038 Load 16'h0001, dir=0, speed=0, 16 ticks -> lane steps 0002, 0004, ... 8000, 0001; exactly 16 step pulses.
REQ-039 speed=2, 9 ticks -> 3 rotations; load asserted in the same cycle as the 2nd tick -> lane=pattern, no rotation, count restarts.
REQ-040 dir=1, load 16'h0001, speed=0, one tick -> lane=16'h8000.
REQ-041 frog_col=5, frog_in_lane=1, load 16'h0010, dir=0, one tick -> lane=16'h0020, next edge hit=1 and HALT; 4 more ticks leave lane unchanged; clear_hit -> hit=0 and RUN (hit re-sets if overlap persists, per REQ-030).
REQ-042 speed lowered from 7 to 1 after 3 counted ticks -> rotation occurs on the very next tick.
